// File: rtl/mem_access_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_access_arbiter - round-robin ICache/DCache arbiter with serial bitmaps
// Option macro: MEM_ACCESS_ARBITER_ORPHAN_CHECK_EN (sticky orphan flag)
// Revision: 1.0
// ==========================================================================
module mem_access_arbiter #(
  parameter int MSHR_NUM       = 2,
  parameter int PHY_ADDR_WIDTH = 32,
  parameter int LINE_BIT_WIDTH = 128,
  parameter int RS_W           = $clog2(MSHR_NUM + 1),
  parameter int WS_W           = $clog2(MSHR_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      icReqValid,
  input  logic [PHY_ADDR_WIDTH-1:0] icReqAddr,
  output logic                      icAck,
  output logic [RS_W-1:0]           icSerial,
  input  logic                      dcReqValid,
  input  logic                      dcReqWe,
  input  logic [PHY_ADDR_WIDTH-1:0] dcReqAddr,
  input  logic [LINE_BIT_WIDTH-1:0] dcReqData,
  output logic                      dcAck,
  output logic [RS_W-1:0]           dcSerial,
  output logic [WS_W-1:0]           dcWSerial,
  output logic                      memReqValid,
  output logic                      memReqWe,
  output logic [PHY_ADDR_WIDTH-1:0] memReqAddr,
  output logic [LINE_BIT_WIDTH-1:0] memReqData,
  output logic [RS_W-1:0]           memReqSerial,
  output logic [WS_W-1:0]           memReqWSerial,
  input  logic                      memReqReady,
  input  logic                      memRdValid,
  input  logic [RS_W-1:0]           memRdSerial,
  input  logic [LINE_BIT_WIDTH-1:0] memRdData,
  input  logic                      memWrValid,
  input  logic [WS_W-1:0]           memWrSerial,
  output logic                      rdResValid,
  output logic [RS_W-1:0]           rdResSerial,
  output logic [LINE_BIT_WIDTH-1:0] rdResData,
  output logic                      wrResValid,
  output logic [WS_W-1:0]           wrResSerial,
  output logic                      errOrphanResp
);

  localparam int   RD_N    = MSHR_NUM + 1;
  localparam int   WR_N    = MSHR_NUM;
  localparam logic PRIO_IC = 1'b0;
  localparam logic PRIO_DC = 1'b1;

  logic [RD_N-1:0] rd_busy, rd_set, rd_clr;
  logic [WR_N-1:0] wr_busy, wr_set, wr_clr;
  logic [RS_W-1:0] rd_idx;
  logic [WS_W-1:0] wr_idx;
  logic            rr_prio;
  logic            slot_free, rd_avail, wr_avail;
  logic            ic_elig, dc_elig, grant_ic, grant_dc, grant_rd, grant_wr;

  // Lowest-index clear bit wins; the downward scan leaves the smallest index last.
  always_comb begin
    rd_idx = '0;
    wr_idx = '0;
    for (int i = RD_N - 1; i >= 0; i--) begin
      if (!rd_busy[i]) rd_idx = RS_W'(i);
    end
    for (int i = WR_N - 1; i >= 0; i--) begin
      if (!wr_busy[i]) wr_idx = WS_W'(i);
    end
  end

  assign rd_avail  = ~&rd_busy;
  assign wr_avail  = ~&wr_busy;
  assign slot_free = !memReqValid || memReqReady;

  assign ic_elig  = !rst && icReqValid && slot_free && rd_avail;
  assign dc_elig  = !rst && dcReqValid && slot_free && (dcReqWe ? wr_avail : rd_avail);
  assign grant_ic = ic_elig && (!dc_elig || rr_prio == PRIO_IC);
  assign grant_dc = dc_elig && (!ic_elig || rr_prio == PRIO_DC);
  assign grant_rd = grant_ic || (grant_dc && !dcReqWe);
  assign grant_wr = grant_dc && dcReqWe;

  assign icAck     = grant_ic;
  assign icSerial  = rd_idx;
  assign dcAck     = grant_dc;
  assign dcSerial  = rd_idx;
  assign dcWSerial = wr_idx;

  // Allocation uses the pre-edge bitmap, so a bit freed this cycle cannot be reallocated yet.
  always_comb begin
    rd_set = '0;
    rd_clr = '0;
    wr_set = '0;
    wr_clr = '0;
    for (int i = 0; i < RD_N; i++) begin
      rd_set[i] = grant_rd && (rd_idx == RS_W'(i));
      rd_clr[i] = memRdValid && (memRdSerial == RS_W'(i));
    end
    for (int i = 0; i < WR_N; i++) begin
      wr_set[i] = grant_wr && (wr_idx == WS_W'(i));
      wr_clr[i] = memWrValid && (memWrSerial == WS_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_busy <= '0;
      wr_busy <= '0;
      rr_prio <= PRIO_IC;
    end else begin
      rd_busy <= (rd_busy & ~rd_clr) | rd_set;
      wr_busy <= (wr_busy & ~wr_clr) | wr_set;
      if (ic_elig && dc_elig) rr_prio <= grant_ic ? PRIO_DC : PRIO_IC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memReqValid <= 1'b0;
    end else if (slot_free) begin
      memReqValid <= grant_ic || grant_dc;
    end
  end

  always_ff @(posedge clk) begin
    if (slot_free && (grant_ic || grant_dc)) begin
      memReqWe      <= grant_wr;
      memReqAddr    <= grant_ic ? icReqAddr : dcReqAddr;
      memReqData    <= dcReqData;
      memReqSerial  <= rd_idx;
      memReqWSerial <= wr_idx;
    end
  end

  assign rdResValid  = memRdValid && !rst;
  assign rdResSerial = memRdSerial;
  assign rdResData   = memRdData;
  assign wrResValid  = memWrValid && !rst;
  assign wrResSerial = memWrSerial;

`ifdef MEM_ACCESS_ARBITER_ORPHAN_CHECK_EN
  logic orphan;
  // Out-of-range serials produce an all-zero clear mask and so also count as orphans.
  assign orphan = (memRdValid && ((rd_busy & rd_clr) == '0)) ||
                  (memWrValid && ((wr_busy & wr_clr) == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      errOrphanResp <= 1'b0;
    end else if (orphan) begin
      errOrphanResp <= 1'b1;
      $error("mem_access_arbiter: response for non-allocated serial");
    end
  end
`else
  assign errOrphanResp = 1'b0;
`endif

endmodule
`default_nettype wire
